// File: rtl/jk_drive_pkg.sv
// Shared types for the JK drive sequencer: FSM state encoding and the
// single-bit JK excitation rule used to derive J/K from current/next Q.
package jk_drive_pkg;

  typedef enum logic [1:0] {
    ST_INIT  = 2'd0,
    ST_IDLE  = 2'd1,
    ST_RUN   = 2'd2,
    ST_FAULT = 2'd3
  } state_e;

  typedef struct packed {
    logic j;
    logic k;
  } jk_t;

  // Don't-care entries of the excitation table resolve to 0, so a held bit
  // is never driven and a changing bit gets exactly one of J or K.
  function automatic jk_t jk_excite(input logic cur, input logic nxt);
    jk_t r;
    r.j = ~cur & nxt;
    r.k = cur & ~nxt;
    return r;
  endfunction

endpackage

// File: rtl/jk_excite_vec.sv
// WIDTH-wide combinational JK excitation: J/K that move cur to nxt in one
// clock of a bank of JK flip-flops.
module jk_excite_vec
  import jk_drive_pkg::*;
#(
  parameter int WIDTH = 4
) (
  input  logic [WIDTH-1:0] cur,
  input  logic [WIDTH-1:0] nxt,
  output logic [WIDTH-1:0] j,
  output logic [WIDTH-1:0] k
);

  for (genvar i = 0; i < WIDTH; i++) begin : g_bit
    assign {j[i], k[i]} = jk_excite(cur[i], nxt[i]);
  end

endmodule

// File: rtl/jk_drive_sequencer.sv
// Sequences a bank of negedge JK flip-flops through an up/down count and
// verifies each step against the fed-back Q, latching a sticky fault.
module jk_drive_sequencer
  import jk_drive_pkg::*;
#(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             clear,
  input  logic             start,
  input  logic             stop,
  input  logic             load,
  input  logic [WIDTH-1:0] load_value,
  input  logic             up_down,
  input  logic             step_en,
  input  logic [WIDTH-1:0] q_fb,
  output logic [WIDTH-1:0] j_out,
  output logic [WIDTH-1:0] k_out,
  output logic [WIDTH-1:0] expected_q,
  output logic             running,
  output logic             wrap,
  output logic             fault
);

  state_e           state;
  logic             check_en;
  logic [WIDTH-1:0] step_nxt;
  logic [WIDTH-1:0] step_j;
  logic [WIDTH-1:0] step_k;
  logic             step_wrap;
  logic             mismatch;

  // Excitation is always computed from the commanded value, never from raw
  // q_fb, so a corrupted bank cannot steer its own next drive.
  assign step_nxt  = up_down ? expected_q + WIDTH'(1) : expected_q - WIDTH'(1);
  assign step_wrap = up_down ? (&expected_q) : ~(|expected_q);

  jk_excite_vec #(.WIDTH(WIDTH)) u_excite (
    .cur (expected_q),
    .nxt (step_nxt),
    .j   (step_j),
    .k   (step_k)
  );

  assign mismatch = check_en && (state != ST_FAULT) && (q_fb != expected_q);
  assign running  = (state == ST_RUN);

  // NOTE: all state uses non-blocking assignments so every register samples
  // pre-edge values; blocking here would let later statements see new state.
  always_ff @(posedge clk) begin
    if (clear) begin
      state      <= ST_INIT;
      j_out      <= '0;
      k_out      <= '1;
      expected_q <= '0;
      wrap       <= 1'b0;
      fault      <= 1'b0;
      check_en   <= 1'b0;
    end else begin
      // Default drive is hold; only a load or step overrides it this edge.
      wrap  <= 1'b0;
      j_out <= '0;
      k_out <= '0;
      if (mismatch) begin
        state <= ST_FAULT;
        fault <= 1'b1;
      end else begin
        case (state)
          ST_INIT: begin
            state    <= ST_IDLE;
            check_en <= 1'b1;
          end
          ST_IDLE: begin
            if (load) begin
              expected_q <= load_value;
              j_out      <= load_value;
              k_out      <= ~load_value;
            end else if (start) begin
              state <= ST_RUN;
            end
          end
          ST_RUN: begin
            if (load) begin
              expected_q <= load_value;
              j_out      <= load_value;
              k_out      <= ~load_value;
            end else if (stop) begin
              state <= ST_IDLE;
            end else if (step_en) begin
              expected_q <= step_nxt;
              j_out      <= step_j;
              k_out      <= step_k;
              wrap       <= step_wrap;
            end
          end
          default: ;  // FAULT holds with j/k = 0 until clear
        endcase
      end
    end
  end

endmodule

// File: tb/tb_jk_drive_sequencer.sv
// Closed-loop bench: a negedge JK bank fed by the sequencer, checked against
// an arithmetic reference model under directed and random stimulus.
module tb_jk_drive_sequencer;

  localparam int W   = 4;
  localparam int MOD = 1 << W;
  localparam int P_INIT = 0, P_IDLE = 1, P_RUN = 2, P_FAULT = 3;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic         clear, start, stop, load, up_down, step_en;
  logic [W-1:0] load_value, q_fb, j_out, k_out, expected_q;
  logic         running, wrap, fault;
  logic [W-1:0] bank_q, inj;

  jk_drive_sequencer #(.WIDTH(W)) dut (
    .clk        (clk),
    .clear      (clear),
    .start      (start),
    .stop       (stop),
    .load       (load),
    .load_value (load_value),
    .up_down    (up_down),
    .step_en    (step_en),
    .q_fb       (q_fb),
    .j_out      (j_out),
    .k_out      (k_out),
    .expected_q (expected_q),
    .running    (running),
    .wrap       (wrap),
    .fault      (fault)
  );

  // Behavioural JK bank (neg_clear tied inactive), sampling on negedge.
  always @(negedge clk) begin
    for (int i = 0; i < W; i++) begin
      case ({j_out[i], k_out[i]})
        2'b01:   bank_q[i] <= 1'b0;
        2'b10:   bank_q[i] <= 1'b1;
        2'b11:   bank_q[i] <= ~bank_q[i];
        default: ;
      endcase
    end
  end
  assign q_fb = bank_q ^ inj;

  int checks = 0;
  int errors = 0;

  int           m_phase, m_val;
  bit           m_chk, m_wrap, m_fault;
  logic [W-1:0] m_j, m_k;

  task automatic check(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // One clock: snapshot inputs and the settled bank, advance the model by
  // the sequencer's rules, then compare every output.
  task automatic tick();
    bit           s_clear, s_start, s_stop, s_load, s_up, s_step;
    logic [W-1:0] s_lv, s_q;
    int           nv;
    @(negedge clk);
    #1;
    s_clear = clear; s_start = start; s_stop = stop; s_load = load;
    s_up = up_down;  s_step = step_en; s_lv = load_value; s_q = q_fb;
    @(posedge clk);
    #1;
    if (s_clear) begin
      m_phase = P_INIT; m_val = 0; m_chk = 0;
      m_j = '0; m_k = '1; m_wrap = 0; m_fault = 0;
    end else begin
      m_j = '0; m_k = '0; m_wrap = 0;
      if (m_chk && m_phase != P_FAULT && s_q !== m_val[W-1:0]) begin
        m_phase = P_FAULT;
        m_fault = 1;
      end else if (m_phase == P_INIT) begin
        m_phase = P_IDLE;
        m_chk   = 1;
      end else if ((m_phase == P_IDLE || m_phase == P_RUN) && s_load) begin
        m_val = int'(s_lv);
        m_j   = s_lv;
        m_k   = ~s_lv;
      end else if (m_phase == P_IDLE && s_start) begin
        m_phase = P_RUN;
      end else if (m_phase == P_RUN && s_stop) begin
        m_phase = P_IDLE;
      end else if (m_phase == P_RUN && s_step) begin
        nv     = s_up ? (m_val + 1) % MOD : (m_val + MOD - 1) % MOD;
        m_wrap = s_up ? (m_val == MOD - 1) : (m_val == 0);
        for (int i = 0; i < W; i++) begin
          if (((m_val >> i) & 1) == 0 && ((nv >> i) & 1) == 1) m_j[i] = 1'b1;
          if (((m_val >> i) & 1) == 1 && ((nv >> i) & 1) == 0) m_k[i] = 1'b1;
        end
        m_val = nv;
      end
    end
    check("j_out", j_out, m_j);
    check("k_out", k_out, m_k);
    check("expected_q", expected_q, m_val[W-1:0]);
    check("wrap", W'(wrap), W'(m_wrap));
    check("fault", W'(fault), W'(m_fault));
    check("running", W'(running), W'(m_phase == P_RUN));
  endtask

  task automatic idle_inputs();
    start = 0; stop = 0; load = 0; step_en = 0;
  endtask

  initial begin
    clear = 1; idle_inputs(); up_down = 1; load_value = '0; inj = '0;

    // 1: reset, INIT with K all ones, bank cleared
    tick(); tick();
    check("reset_k", k_out, 4'hF);
    clear = 0;
    tick();
    check("init_exit_k", k_out, 4'h0);
    tick();
    check("bank_init", q_fb, 4'h0);
    check("fault_init", W'(fault), W'(0));

    // 2: load 4'hA in IDLE
    load = 1; load_value = 4'hA;
    tick();
    check("load_j", j_out, 4'hA);
    check("load_k", k_out, 4'h5);
    load = 0;
    tick();
    check("bank_load", q_fb, 4'hA);

    // 3: count up from E through the wrap
    load = 1; load_value = 4'hE; tick();
    load = 0; start = 1; tick();
    start = 0; up_down = 1; step_en = 1;
    tick(); check("up_e_f", expected_q, 4'hF); check("up_wrap0", W'(wrap), W'(0));
    tick(); check("up_f_0", expected_q, 4'h0); check("up_wrap1", W'(wrap), W'(1));
    tick(); check("up_0_1", expected_q, 4'h1); check("bank_up", q_fb, 4'h0);

    // 4: count down with step_en 1,0,1
    up_down = 0;
    tick(); check("dn_1_0", expected_q, 4'h0);
    step_en = 0;
    tick(); check("dn_hold", expected_q, 4'h0); check("dn_hold_j", j_out, 4'h0);
    step_en = 1;
    tick(); check("dn_0_f", expected_q, 4'hF); check("dn_wrap", W'(wrap), W'(1));
    step_en = 0;
    tick(); check("bank_dn", q_fb, 4'hF);

    // 5: single-cycle feedback corruption
    inj = 4'b0100;
    tick();
    inj = '0;
    check("fault_set", W'(fault), W'(1));
    check("fault_run", W'(running), W'(0));
    start = 1; load = 1; load_value = 4'h3;
    tick(); tick();
    check("fault_hold_q", expected_q, 4'hF);
    idle_inputs();

    // 6: clear mid-RUN with load and step in the same cycle
    clear = 1; tick(); clear = 0; tick(); tick();
    start = 1; tick(); start = 0;
    step_en = 1; up_down = 0; tick();
    clear = 1; load = 1; load_value = 4'h9;
    tick();
    check("clr_q", expected_q, 4'h0);
    check("clr_wrap", W'(wrap), W'(0));
    clear = 0; idle_inputs();
    tick();
    check("clr_bank", q_fb, 4'h0);

    // Random closed-loop traffic
    for (int n = 0; n < 400; n++) begin
      clear      = ($urandom_range(0, 39) == 0);
      load       = ($urandom_range(0, 7) == 0);
      start      = ($urandom_range(0, 3) == 0);
      stop       = ($urandom_range(0, 9) == 0);
      step_en    = $urandom_range(0, 1);
      up_down    = $urandom_range(0, 1);
      load_value = W'($urandom);
      inj        = ($urandom_range(0, 59) == 0) ? W'(1 << $urandom_range(0, W - 1)) : '0;
      tick();
      inj = '0;
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
